// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/IO arbiter for a single synchronous-read RAM
module mem_arbiter #(
  parameter int ADDRBITS = 16,
  parameter int DATABITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDRBITS-1:0] cpu_addr,
  input  logic [DATABITS-1:0] cpu_wdata,
  output logic [DATABITS-1:0] cpu_rdata,
  output logic                cpu_done,
  output logic                cpu_stall,
  input  logic                io_req,
  input  logic [ADDRBITS-1:0] io_addr,
  output logic [DATABITS-1:0] io_rdata,
  output logic                io_done,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDRBITS-1:0] ram_addr,
  output logic [DATABITS-1:0] ram_wdata,
  input  logic [DATABITS-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_RSP, IO_ACC, IO_RSP} state_t;

  state_t              state, state_nxt;
  logic                last_io;
  logic                grant_cpu, grant_io;
  logic                cpu_elig, io_elig;
  logic [ADDRBITS-1:0] addr_q;
  logic                we_q;
  logic [DATABITS-1:0] wdata_q;

  // A requester whose done is showing this cycle has just been served
  assign cpu_elig  = cpu_req && !cpu_done;
  assign io_elig   = io_req && !io_done;
  assign cpu_stall = cpu_req && !cpu_done;

  // Next-state, grant decision and RAM drive; RAM pins are only live in the access states
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_io  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (cpu_elig && (!io_elig || last_io)) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_ACC;
        end else if (io_elig) begin
          grant_io  = 1'b1;
          state_nxt = IO_ACC;
        end
      end
      CPU_ACC: begin
        ram_en    = 1'b1;
        ram_we    = we_q;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        state_nxt = CPU_RSP;
      end
      IO_ACC: begin
        ram_en    = 1'b1;
        ram_addr  = addr_q;
        state_nxt = IO_RSP;
      end
      CPU_RSP: state_nxt = IDLE;
      IO_RSP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset forces IDLE so RAM enables drop without a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Capture the winner's request so later input changes cannot disturb it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      last_io <= 1'b1;
    end else if (grant_cpu) begin
      addr_q  <= cpu_addr;
      we_q    <= cpu_we;
      wdata_q <= cpu_wdata;
      last_io <= 1'b0;
    end else if (grant_io) begin
      addr_q  <= io_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
      last_io <= 1'b1;
    end
  end

  // Completion: one-cycle done pulse, read data registered on leaving the response state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_done  <= 1'b0;
      io_done   <= 1'b0;
      cpu_rdata <= '0;
      io_rdata  <= '0;
    end else begin
      cpu_done <= (state == CPU_RSP);
      io_done  <= (state == IO_RSP);
      if (state == CPU_RSP && !we_q) cpu_rdata <= ram_rdata;
      if (state == IO_RSP)           io_rdata  <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        io_req;
  logic [15:0] io_addr, io_rdata;
  logic        io_done;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr, ram_wdata;
  logic [15:0] ram_rdata;

  logic        ld_en;
  logic [15:0] ld_addr, ld_data;
  logic [15:0] mem [0:65535];

  typedef struct packed {
    logic        is_io;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDRBITS(16), .DATABITS(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .io_req(io_req), .io_addr(io_addr), .io_rdata(io_rdata), .io_done(io_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with a bench-side preload port
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (cpu_done && io_done) chk("both_done", 1, 0);
    else if (cpu_done || io_done) begin
      chk("done_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done_port", io_done, e.is_io);
        chk("done_rdata", e.is_io ? io_rdata : cpu_rdata, e.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic push(input logic is_io, input logic [15:0] d);
    exp_t e;
    e.is_io = is_io;
    e.data  = d;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    io_req = 0; io_addr = 0; ld_en = 0; ld_addr = 0; ld_data = 0; ram_rdata = 0;
    preload(16'h0010, 16'hBEEF);
    preload(16'h0005, 16'h5555);
    preload(16'h0020, 16'h0000);
    preload(16'h0030, 16'h3030);
    preload(16'h0040, 16'h4040);
    preload(16'h0041, 16'h4141);

    // Reset state
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_io_done", io_done, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_io_rdata", io_rdata, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    reset = 1'b0;
    step();

    // CPU load
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    push(0, 16'hBEEF);
    #1 chk("ld_stall0", cpu_stall, 1);
    step();
    chk("ld_ram_en", ram_en, 1);
    chk("ld_ram_addr", ram_addr, 16'h0010);
    chk("ld_ram_we", ram_we, 0);
    chk("ld_stall1", cpu_stall, 1);
    step();
    chk("ld_rsp_en", ram_en, 0);
    chk("ld_stall2", cpu_stall, 1);
    step();
    chk("ld_done", cpu_done, 1);
    chk("ld_stall3", cpu_stall, 0);
    cpu_req = 0;
    step();
    chk("ld_done_clr", cpu_done, 0);
    chk("ld_rdata_hold", cpu_rdata, 16'hBEEF);

    // CPU store then load back
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    push(0, 16'hBEEF);
    step();
    chk("st_ram_en", ram_en, 1);
    chk("st_ram_we", ram_we, 1);
    chk("st_ram_addr", ram_addr, 16'h0020);
    chk("st_ram_wdata", ram_wdata, 16'h1234);
    step();
    chk("st_we_once", ram_we, 0);
    step();
    chk("st_done", cpu_done, 1);
    cpu_req = 0; cpu_we = 0;
    step();
    cpu_req = 1; cpu_addr = 16'h0020;
    push(0, 16'h1234);
    step(); step(); step();
    chk("st_ld_done", cpu_done, 1);
    cpu_req = 0;
    step();

    // Tie after reset: CPU, IO, CPU, IO, grants 3 cycles apart
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("tie_rst_rdata", cpu_rdata, 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    io_req = 1; io_addr = 16'h0005;
    push(0, 16'hBEEF); push(1, 16'h5555); push(0, 16'hBEEF); push(1, 16'h5555);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("tie_ram_en", ram_en, ((k - 1) % 3) == 0);
      if (((k - 1) % 3) == 0)
        chk("tie_ram_addr", ram_addr, ((((k - 1) / 3) % 2) == 0) ? 16'h0010 : 16'h0005);
      chk("tie_cpu_done", cpu_done, (k % 3 == 0) && (((k / 3 - 1) % 2) == 0));
      chk("tie_io_done", io_done, (k % 3 == 0) && (((k / 3 - 1) % 2) == 1));
    end
    cpu_req = 0; io_req = 0;
    step();

    // Lone IO requester: one grant per 4 cycles, never a write
    io_req = 1; io_addr = 16'h0005;
    push(1, 16'h5555); push(1, 16'h5555); push(1, 16'h5555);
    for (int k = 1; k <= 11; k++) begin
      step();
      chk("io_ram_en", ram_en, (k % 4) == 1);
      chk("io_ram_we", ram_we, 0);
      chk("io_done", io_done, (k % 4) == 3);
    end
    io_req = 0;
    step();
    chk("io_idle", ram_en, 0);

    // Reset in the middle of a store access
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'hAAAA;
    step();
    chk("ra_ram_en", ram_en, 1);
    chk("ra_ram_we", ram_we, 1);
    reset = 1'b1;
    #1;
    chk("ra_en_drop", ram_en, 0);
    chk("ra_we_drop", ram_we, 0);
    chk("ra_addr0", ram_addr, 0);
    chk("ra_wdata0", ram_wdata, 0);
    chk("ra_cpu_rdata0", cpu_rdata, 0);
    chk("ra_io_rdata0", io_rdata, 0);
    cpu_req = 0; cpu_we = 0;
    step();
    step();
    chk("ra_no_done", cpu_done, 0);
    reset = 1'b0;
    step();
    chk("ra_mem_kept", mem[16'h0030], 16'h3030);

    // Address change after grant does not affect the transaction
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    push(0, 16'h4040);
    step();
    cpu_addr = 16'h0041;
    #1 chk("ac_ram_addr", ram_addr, 16'h0040);
    step(); step();
    chk("ac_done", cpu_done, 1);
    cpu_req = 0;
    step();
    chk("ac_rdata", cpu_rdata, 16'h4040);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
